apb_pwm_gen: RTL
================

// Module: apb_pwm_gen
// PURPOSE
//  APB slave PWM generator on APB slot 2 (PSEL2/PREADY2/PRDATA2/PSLVERR2 of the APB slave mux).
//  It drives the actuator of the ADC->CORDIC->PID loop.
//  Firmware programs period and duty through shadow registers. Active values update only at a
//  period boundary, so glitch-free duty changes are guaranteed. A wrap flag/IRQ paces the control loop.
// PARAMETERS
//  CNT_W   16  width of period/duty/counter registers (2..32)
// PORTS
//  clk      in   1      single clock (APB PCLK domain)
//  rst      in   1      asynchronous, active-high reset
//  PSEL     in   1      APB select
//  PENABLE  in   1      APB access phase
//  PWRITE   in   1      APB write
//  PADDR    in   12     APB byte address, offset within slot; [1:0] ignored
//  PWDATA   in   32     APB write data
//  PRDATA   out  32     APB read data
//  PREADY   out  1      always 1 (zero wait state)
//  PSLVERR  out  1      error on unmapped offset
//  pwm_p    out  1      PWM output (high side)
//  pwm_n    out  1      complementary PWM output (low side)
//  irq      out  1      period-wrap interrupt, level
// BEHAVIOUR
//  Reset: all registers 0; cnt=0; pwm_p=0, pwm_n=0, irq=0, PRDATA=0, PSLVERR=0; PREADY=1 always.
//  Register map (offset):
//   0x00 CTRL   RW [0]EN [1]POL(invert both outputs) [2]IRQ_EN
//   0x04 PERIOD RW shadow [CNT_W-1:0]; 0x08 DUTY RW shadow [CNT_W-1:0]; reads return shadow
//   0x0C CNT    RO live counter; 0x10 STAT [0]WRAP, write-1-to-clear
//   0x14 DEADT  RW [7:0] (PWM_DEADTIME_EN only, else RAZ/WI but mapped)
//  - Write commits on clk edge with PSEL&PENABLE&PWRITE; unused high bits are ignored and read as 0.
//  - PRDATA is combinational. It equals the register when PSEL&~PWRITE, and 0 otherwise.
//  - PSLVERR = PSEL&PENABLE & offset>0x14. An erroring write has no effect.
//  - Counter: EN=0 -> cnt held 0, active regs follow shadows each cycle.
//    EN=1 -> cnt counts 0..per_act. At cnt==per_act, cnt goes to 0 and per_act/duty_act
//    load from the shadows in the same edge.
//  - per_act=0: cnt stays 0, each cycle is a wrap.
//  - raw = EN & (cnt < duty_act). pwm_p = raw^POL, registered, so there is 1 cycle of latency from cnt.
//    duty_act=0 -> constant low. duty_act>per_act -> constant high.
//  - EN=0 -> pwm_p=POL, pwm_n=POL (both idle inactive when POL=0).
//  - WRAP set on every wrap while EN=1. irq = WRAP & IRQ_EN, registered.
//    If a W1C and a wrap occur in the same cycle, set wins.
//  - Writing EN 1->0 mid-period stops immediately (cnt=0 next cycle); WRAP is kept.
//  - Reset asserted mid-period: all state cleared asynchronously and outputs drop immediately.
// CONFIGURATION
//  PWM_DEADTIME_EN defined:
//   - pwm_n = complement of raw with dead-band insertion, using an 8-bit down-counter.
//   - A rising edge of an output is delayed DEADT cycles after the raw transition; falling edges are not delayed.
//   - If the pulse is no longer than DEADT, that output stays inactive for that pulse.
//   - DEADT=0 gives pwm_n = ~pwm_p exactly (EN=1). POL applies after insertion.
//  Undefined: pwm_n = (EN ? ~raw : 0)^POL, registered alongside pwm_p. DEADT reads 0.
// TESTING
//  T1 reset: rst=1 async mid-cycle -> pwm_p=pwm_n=irq=0, PRDATA=0, CNT reads 0 after release.
//  T2 basic: PERIOD=9, DUTY=3, EN=1 -> pwm_p high 3 of every 10 clks; WRAP every 10 clks;
//     CNT reads 0..9.
//  T3 shadow: at cnt=5, write DUTY=7 -> current period stays 3-high; next period is 7-high; no glitch.
//  T4 bounds: DUTY=0 -> pwm_p constant 0. DUTY=12 with PERIOD=9 -> constant 1.
//     PERIOD=0, DUTY=1 -> constant 1 with WRAP every clk.
//  T5 irq/APB: IRQ_EN=1 -> irq=1 one clk after wrap. Write STAT=1 at a wrap cycle -> WRAP stays 1.
//     Read 0x20 -> PSLVERR=1.
//  T6 PWM_DEADTIME_EN: DEADT=2, PERIOD=9, DUTY=5 -> pwm_p high 3 clks, pwm_n high 3 clks,
//     2-clk gaps both sides. DUTY=1 -> pwm_p never high.

Source files
------------

// File: rtl/apb_pwm_gen.sv
// APB slave PWM generator: shadowed period/duty, wrap flag and level IRQ.
// Define PWM_DEADTIME_EN to enable dead-band insertion on pwm_p/pwm_n.
module apb_pwm_gen #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        pwm_p,
    output logic        pwm_n,
    output logic        irq
);
    localparam logic [9:0] A_CTRL  = 10'd0;
    localparam logic [9:0] A_PER   = 10'd1;
    localparam logic [9:0] A_DUTY  = 10'd2;
    localparam logic [9:0] A_CNT   = 10'd3;
    localparam logic [9:0] A_STAT  = 10'd4;
    localparam logic [9:0] A_DEADT = 10'd5;

    logic [9:0]       widx;
    logic             acc;
    logic             wr;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             irq_q;
    logic             pwm_p_q, pwm_p_d;
    logic             pwm_n_q, pwm_n_d;
    logic [7:0]       deadt_q;
    logic             en;
    logic             pol;
    logic             at_end;
    logic             raw;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign widx        = PADDR[11:2];
    assign acc         = PSEL & PENABLE;
    assign PSLVERR     = acc & (widx > A_DEADT);
    assign wr          = acc & PWRITE & ~PSLVERR;
    assign PREADY      = 1'b1;
    assign en          = ctrl_q[0];
    assign pol         = ctrl_q[1];
    assign at_end      = (cnt_q == per_act_q);
    assign raw         = en & (cnt_q < duty_act_q);
    assign unused_bits = ^{PWDATA, PADDR[1:0]};

    always_comb begin
        ctrl_d    = ctrl_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (wr) begin
            case (widx)
                A_CTRL:  ctrl_d    = PWDATA[2:0];
                A_PER:   per_sh_d  = PWDATA[CNT_W-1:0];
                A_DUTY:  duty_sh_d = PWDATA[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Active period/duty only change while idle or at the wrap edge.
    always_comb begin
        cnt_d      = '0;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        if (!en) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end else if (at_end) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        if (wr && widx == A_STAT && PWDATA[0])
            wrap_d = 1'b0;
        if (en && at_end)
            wrap_d = 1'b1;
    end

`ifdef PWM_DEADTIME_EN
    logic       raw_q;
    logic [7:0] dt_q, dt_d, rem;

    // rem: cycles still to hold off the rising output after a raw edge.
    always_comb begin
        rem     = (raw != raw_q) ? deadt_q : dt_q;
        dt_d    = (rem == 8'd0) ? 8'd0 : rem - 8'd1;
        pwm_p_d = (raw & (rem == 8'd0)) ^ pol;
        pwm_n_d = (en & ~raw & (rem == 8'd0)) ^ pol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_q   <= 1'b0;
            dt_q    <= 8'd0;
            deadt_q <= 8'd0;
        end else begin
            raw_q <= raw;
            dt_q  <= dt_d;
            if (wr && widx == A_DEADT)
                deadt_q <= PWDATA[7:0];
        end
    end
`else
    assign deadt_q = 8'd0;

    always_comb begin
        pwm_p_d = raw ^ pol;
        pwm_n_d = (en & ~raw) ^ pol;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            irq_q      <= 1'b0;
            pwm_p_q    <= 1'b0;
            pwm_n_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            irq_q      <= wrap_q & ctrl_q[2];
            pwm_p_q    <= pwm_p_d;
            pwm_n_q    <= pwm_n_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (widx)
            A_CTRL:  rdata[2:0]       = ctrl_q;
            A_PER:   rdata[CNT_W-1:0] = per_sh_q;
            A_DUTY:  rdata[CNT_W-1:0] = duty_sh_q;
            A_CNT:   rdata[CNT_W-1:0] = cnt_q;
            A_STAT:  rdata[0]         = wrap_q;
            A_DEADT: rdata[7:0]       = deadt_q;
            default: ;
        endcase
    end

    assign PRDATA = (PSEL & ~PWRITE) ? rdata : 32'd0;
    assign pwm_p  = pwm_p_q;
    assign pwm_n  = pwm_n_q;
    assign irq    = irq_q;
endmodule
